score_update_arbiter: RTL and testbench
=======================================

# score_update_arbiter

Round-robin arbiter and accumulator that serialises score-increment requests from several game-logic requesters into one saturating score register. The registered score drives the 10-bit score value input of the score-value PIO, so software reads a value that changes only on whole, arbitrated updates. Clear requests from game reset logic take priority over any pending update.

## Interface

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DELTA_W, 4, width of each requester's increment
- SCORE_W, 10, score width, matching the PIO input width
- SCORE_MAX, 999, saturation ceiling, must be less than 2**SCORE_W

Ports:
- clk  input  1  system clock
- reset  input  1  reset; one clock, asynchronous, active-high
- req_valid  input  NUM_REQ  per-requester update request
- req_delta  input  NUM_REQ*DELTA_W  per-requester increment; requester i uses bits [i*DELTA_W +: DELTA_W]
- req_ready  output  NUM_REQ  one-hot acknowledge, high for exactly one cycle per accepted request
- clear  input  1  synchronous score clear
- score  output  SCORE_W  current score; connects to the PIO in_port
- score_updated  output  1  one-cycle pulse after every change in score value
- saturated  output  1  high once any update clipped at SCORE_MAX; cleared by clear or reset
- busy  output  1  high while the FSM is in APPLY

## Operation

- FSM states:
  - IDLE: if any req_valid bit is high and clear is low, register grant index g and delta d = req_delta[g], then go to APPLY. Otherwise stay in IDLE.
  - APPLY: assert req_ready[g]. Compute sum = score + d in SCORE_W+1 bits.
    - If sum > SCORE_MAX: score <= SCORE_MAX and saturated <= 1.
    - Otherwise: score <= sum.
    - Set the round-robin pointer to (g+1) mod NUM_REQ, then go to IDLE.
- Round robin: search upward from the pointer, wrapping, and take the first requester with req_valid high. The pointer is 0 after reset.
- Handshake:
  - A requester holds valid and delta until it sees req_ready high.
  - It may deassert valid in the cycle after ready, or keep valid high to request again.
  - d is latched at grant. A valid or delta change during APPLY does not affect the update.
  - Dropping valid in IDLE before a grant withdraws the request; no ack is issued.
- Clear:
  - Any state: score <= 0, saturated <= 0, FSM goes to IDLE. The pointer is not reset.
  - Clear in APPLY: req_ready[g] is still asserted, so the requester is released, and d is discarded.
  - Clear in IDLE blocks a new grant that cycle.
- score_updated pulses only when the score register changes value. Delta 0, clear while the score is already 0, and a clip while already at SCORE_MAX produce no pulse.

## Timing

- Reset values: score 0, req_ready 0, score_updated 0, saturated 0, busy 0, FSM IDLE, pointer 0.
- Request sampled in IDLE at edge k:
  - APPLY during cycle k..k+1, with req_ready[g] and busy high.
  - The new score is visible from edge k+1.
  - score_updated is high for the one cycle after edge k+1.
- Throughput: at most one update every 2 cycles. Back-to-back requests from different requesters are granted in alternate cycles.
- Clear asserted at edge k gives score 0 from edge k+1. The score_updated pulse follows the same rule as an update.
- Reset asserted mid-APPLY: all state and outputs return to reset values immediately. The pending request is not acknowledged.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure

- Package score_ctrl_pkg:
  - state enum {IDLE, APPLY}
  - default SCORE_MAX constant
  - function for the saturating add
- Sub-module rr_arbiter: combinational search of NUM_REQ requests from the pointer. Outputs grant index and any_valid. It is reusable for the other shared PIO paths.
- The top level holds the FSM, grant/delta latches, score register and flags.

## Test plan

- Single requester: reset, then req_valid[1]=1 with delta 5 → req_ready[1] pulses once, score 5 two cycles after the request, one score_updated pulse.
- Fairness: all 4 requesters valid continuously with delta 1 → grants 0,1,2,3,0 in alternate cycles, and score 5 after 10 cycles.
- Saturation: score 995, requester delta 9 → score 999 and saturated 1. A further delta 3 gives an ack, score 999, and no score_updated pulse.
- Clear collision: clear asserted in the APPLY cycle of a delta 7 grant from score 10 → req_ready pulses, score 0, saturated 0, and the next grant comes from pointer g+1.
- Reset mid-operation: reset raised during APPLY → req_ready, busy and score immediately 0. After release, the still-valid requester is granted from pointer 0.
- Zero delta and withdrawal: delta 0 gives an ack, unchanged score and no score_updated pulse. A valid pulse dropped before the grant gives no req_ready.

Source files
------------

// File: rtl/score_ctrl_pkg.sv
// Shared types and helpers for the score update path: FSM states, the default
// saturation ceiling and the saturating add used by the score register.
package score_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam int unsigned SCORE_MAX_DEFAULT = 999;

  function automatic int unsigned sat_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned ceil);
    int unsigned s;
    s = a + b;
    return (s > ceil) ? ceil : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid request at or above ptr, wrapping.
// Kept generic so the other shared PIO paths can reuse it.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_valid
);

  always_comb begin
    int j;
    grant_idx = '0;
    any_valid = 1'b0;
    j         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_valid && req[j]) begin
        any_valid = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/score_update_arbiter.sv
// Serialises score increments from several requesters into one saturating
// score register; clear has priority over any pending update.
//
// state | meaning
// IDLE  | waiting for a request; grant latched on the edge leaving IDLE
// APPLY | req_ready/busy high; latched delta added on the edge leaving APPLY
module score_update_arbiter
  import score_ctrl_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          DELTA_W   = 4,
  parameter int          SCORE_W   = 10,
  parameter int unsigned SCORE_MAX = SCORE_MAX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DELTA_W-1:0] req_delta,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       clear,
  output logic [SCORE_W-1:0]         score,
  output logic                       score_updated,
  output logic                       saturated,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [DELTA_W-1:0] delta_q;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [DELTA_W-1:0] arb_delta;
  logic [SCORE_W:0]   sum;
  logic               clip;
  logic [SCORE_W-1:0] score_next;
  logic [IDX_W-1:0]   ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant_idx (arb_idx),
    .any_valid (arb_any)
  );

  assign arb_delta  = req_delta[arb_idx*DELTA_W +: DELTA_W];
  assign sum        = {1'b0, score} + (SCORE_W+1)'(delta_q);
  assign clip       = sum > (SCORE_W+1)'(SCORE_MAX);
  assign score_next = SCORE_W'(sat_add(32'(score), 32'(delta_q), SCORE_MAX));
  assign ptr_next   = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_q       <= '0;
      delta_q       <= '0;
      req_ready     <= '0;
      score         <= '0;
      score_updated <= 1'b0;
      saturated     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      req_ready     <= '0;
      score_updated <= 1'b0;
      if (clear) begin
        // An in-flight grant was already acknowledged; its delta is dropped
        // but the pointer still moves past it.
        score         <= '0;
        saturated     <= 1'b0;
        score_updated <= (score != '0);
        busy          <= 1'b0;
        state         <= IDLE;
        if (state == APPLY) ptr <= ptr_next;
      end else begin
        case (state)
          IDLE: begin
            if (arb_any) begin
              grant_q   <= arb_idx;
              delta_q   <= arb_delta;
              req_ready <= NUM_REQ'(1) << arb_idx;
              busy      <= 1'b1;
              state     <= APPLY;
            end
          end
          APPLY: begin
            score         <= score_next;
            score_updated <= (score_next != score);
            if (clip) saturated <= 1'b1;
            ptr           <= ptr_next;
            busy          <= 1'b0;
            state         <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_update_arbiter.sv
// Directed bench for score_update_arbiter: handshake, fairness, saturation,
// clear priority, asynchronous reset and withdrawal.
module tb_score_update_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DELTA_W = 4;
  localparam int SCORE_W = 10;

  logic                       clk;
  logic                       reset;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DELTA_W-1:0] req_delta;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       clear;
  logic [SCORE_W-1:0]         score;
  logic                       score_updated;
  logic                       saturated;
  logic                       busy;

  int checks   = 0;
  int failures = 0;

  score_update_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DELTA_W   (DELTA_W),
    .SCORE_W   (SCORE_W),
    .SCORE_MAX (999)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_delta     (req_delta),
    .req_ready     (req_ready),
    .clear         (clear),
    .score         (score),
    .score_updated (score_updated),
    .saturated     (saturated),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_delta(input int idx, input logic [DELTA_W-1:0] d);
    req_delta[idx*DELTA_W +: DELTA_W] = d;
  endtask

  // Raise one request, wait (bounded) for its ack, drop it, then step past the apply edge.
  task automatic do_req(input int idx, input logic [DELTA_W-1:0] d);
    bit seen;
    seen = 1'b0;
    set_delta(idx, d);
    req_valid[idx] = 1'b1;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      if (req_ready[idx] === 1'b1) seen = 1'b1;
    end
    req_valid[idx] = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL do_req_ack req=%0d: no req_ready seen, expected ack within 8 cycles", idx);
    end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (saturated !== 1'b0) begin failures++; $display("FAIL reset_saturated: got %b expected 0", saturated); end
    checks++; if (score_updated !== 1'b0) begin failures++; $display("FAIL reset_updated: got %b expected 0", score_updated); end
  endtask

  task automatic test_single();
    set_delta(1, 4'd5);
    req_valid = 4'b0010;
    tick();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", busy); end
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL single_score_early: got %0d expected 0", score); end
    req_valid = 4'b0000;
    tick();
    checks++; if (score !== 10'd5) begin failures++; $display("FAIL single_score: got %0d expected 5", score); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL single_updated: got %b expected 1", score_updated); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL single_ready_drop: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_drop: got %b expected 0", busy); end
    tick();
    checks++; if (score_updated !== 1'b0) begin failures++; $display("FAIL single_updated_once: got %b expected 0", score_updated); end
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL single_ready_once: got %b expected 0000", req_ready); end
  endtask

  task automatic test_fairness();
    logic [NUM_REQ-1:0] exp_ready;
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_delta(i, 4'd1);
    req_valid = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp_ready = (e % 2 == 1) ? (4'b0001 << (((e - 1) / 2) % 4)) : 4'b0000;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL fair_ready edge=%0d: got %b expected %b", e, req_ready, exp_ready);
      end
    end
    req_valid = 4'b0000;
    checks++; if (score !== 10'd5) begin failures++; $display("FAIL fair_score: got %0d expected 5", score); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 66; i++) do_req(0, 4'd15);
    do_req(0, 4'd5);
    checks++; if (score !== 10'd995) begin failures++; $display("FAIL sat_setup: got %0d expected 995", score); end
    do_req(2, 4'd9);
    checks++; if (score !== 10'd999) begin failures++; $display("FAIL sat_clip_score: got %0d expected 999", score); end
    checks++; if (saturated !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b expected 1", saturated); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL sat_clip_updated: got %b expected 1", score_updated); end
    do_req(2, 4'd3);
    checks++; if (score !== 10'd999) begin failures++; $display("FAIL sat_hold_score: got %0d expected 999", score); end
    checks++; if (score_updated !== 1'b0) begin failures++; $display("FAIL sat_hold_updated: got %b expected 0", score_updated); end
    checks++; if (saturated !== 1'b1) begin failures++; $display("FAIL sat_hold_flag: got %b expected 1", saturated); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL sat_clear_score: got %0d expected 0", score); end
    checks++; if (saturated !== 1'b0) begin failures++; $display("FAIL sat_clear_flag: got %b expected 0", saturated); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL sat_clear_updated: got %b expected 1", score_updated); end
  endtask

  task automatic test_clear_collision();
    do_req(0, 4'd10);
    checks++; if (score !== 10'd10) begin failures++; $display("FAIL coll_setup: got %0d expected 10", score); end
    set_delta(1, 4'd7);
    req_valid = 4'b0010;
    tick();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL coll_ready: got %b expected 0010", req_ready); end
    clear = 1'b1;
    req_valid = 4'b0000;
    tick();
    clear = 1'b0;
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL coll_score: got %0d expected 0", score); end
    checks++; if (saturated !== 1'b0) begin failures++; $display("FAIL coll_saturated: got %b expected 0", saturated); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL coll_updated: got %b expected 1", score_updated); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL coll_busy: got %b expected 0", busy); end
    set_delta(2, 4'd3);
    req_valid = 4'b0110;
    tick();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL coll_next_grant: got %b expected 0100", req_ready); end
    req_valid = 4'b0000;
    tick();
    checks++; if (score !== 10'd3) begin failures++; $display("FAIL coll_next_score: got %0d expected 3", score); end
  endtask

  task automatic test_reset_mid_apply();
    set_delta(1, 4'd2);
    set_delta(3, 4'd4);
    req_valid = 4'b1010;
    tick();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL rst_pre_grant: got %b expected 1000", req_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL rst_score: got %0d expected 0", score); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rst_ptr_grant: got %b expected 0010", req_ready); end
    req_valid = 4'b0000;
    tick();
    checks++; if (score !== 10'd2) begin failures++; $display("FAIL rst_after_score: got %0d expected 2", score); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL rst_after_updated: got %b expected 1", score_updated); end
  endtask

  task automatic test_zero_and_withdraw();
    do_req(0, 4'd0);
    checks++; if (score !== 10'd2) begin failures++; $display("FAIL zero_score: got %0d expected 2", score); end
    checks++; if (score_updated !== 1'b0) begin failures++; $display("FAIL zero_updated: got %b expected 0", score_updated); end
    req_valid[2] = 1'b1;
    #3 req_valid[2] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (req_ready !== 4'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL withdraw cycle=%0d: ready=%b busy=%b expected 0000/0", n, req_ready, busy);
      end
    end
  endtask

  task automatic test_clear_idle();
    set_delta(0, 4'd6);
    req_valid = 4'b0001;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL clr_idle_block: got %b expected 0000", req_ready); end
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL clr_idle_score: got %0d expected 0", score); end
    checks++; if (score_updated !== 1'b1) begin failures++; $display("FAIL clr_idle_updated: got %b expected 1", score_updated); end
    tick();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL clr_idle_grant: got %b expected 0001", req_ready); end
    req_valid = 4'b0000;
    tick();
    checks++; if (score !== 10'd6) begin failures++; $display("FAIL clr_idle_after: got %0d expected 6", score); end
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    checks++; if (score_updated !== 1'b0) begin failures++; $display("FAIL clr_zero_no_pulse: got %b expected 0", score_updated); end
    checks++; if (score !== 10'd0) begin failures++; $display("FAIL clr_zero_score: got %0d expected 0", score); end
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    req_valid = '0;
    req_delta = '0;
    test_reset();
    test_single();
    test_fairness();
    test_saturation();
    test_clear_collision();
    test_reset_mid_apply();
    test_zero_and_withdraw();
    test_clear_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
